pb_uart_rx_capture: RTL and testbench

- Synthesizable UART receiver. It is the receiving end of the SoC's uart_tx_o line.
- Deserializes 8N1 / 8E1 / 8O1 frames into bytes and buffers them in a small FIFO.
- Presents bytes on a valid/ready stream.
- Used in the picobello fixture and FPGA harness to capture DUT console output without a behavioural VIP.

---
 rtl/pb_uart_rx_capture.sv | 224 ++++++++++++++++++++++
 tb/tb_pb_uart_rx_capture.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_uart_rx_capture.sv
// pb_uart_rx_capture: UART receiver for 8N1/8E1/8O1 frames with a
// first-word-fall-through byte FIFO on a valid/ready output stream.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   clk_div_i              clock cycles per bit (values below 4 act as 4)
//   parity_en_i/_odd_i     parity enable and odd/even select
//   rx_i                   asynchronous serial line, idle high
//   data_o/valid_o/ready_i byte stream at FIFO head
//   busy_o                 receiver FSM is not idle
//   frame_err_o, parity_err_o, overflow_o  one-cycle error pulses
module pb_uart_rx_capture #(
    parameter int unsigned FifoDepth   = 8,
    parameter int unsigned ClkDivWidth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [ClkDivWidth-1:0] clk_div_i,
    input  logic                   parity_en_i,
    input  logic                   parity_odd_i,
    input  logic                   rx_i,
    output logic [7:0]             data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   busy_o,
    output logic                   frame_err_o,
    output logic                   parity_err_o,
    output logic                   overflow_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [ClkDivWidth-1:0] MinDiv = ClkDivWidth'(4);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_e;

    state_e                 state_q, state_d;
    logic [ClkDivWidth-1:0] cnt_q, cnt_d;
    logic [ClkDivWidth-1:0] div_q, div_d;
    logic [ClkDivWidth-1:0] div_in_c;
    logic                   par_en_q, par_en_d;
    logic                   par_odd_q, par_odd_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic                   perr_q, perr_d;
    logic                   busy_q;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   push_c;
    logic                   sample_c;
    logic                   rx_meta, rx_s;

    // Two-flop synchronizer; resets to the idle line level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    assign div_in_c = (clk_div_i < MinDiv) ? MinDiv : clk_div_i;
    assign sample_c = (cnt_q == '0);

    // Next-state, bit counter and frame assembly
    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q != '0) ? cnt_q - ClkDivWidth'(1) : cnt_q;
        div_d        = div_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        shreg_d      = shreg_q;
        bit_idx_d    = bit_idx_q;
        perr_d       = perr_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        push_c       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d   = ST_START;
                    div_d     = div_in_c;
                    par_en_d  = parity_en_i;
                    par_odd_d = parity_odd_i;
                    // Entry happens one cycle after t0, hence the -1
                    cnt_d     = (div_in_c >> 1) - ClkDivWidth'(1);
                    bit_idx_d = 3'd0;
                    perr_d    = 1'b0;
                end
            end
            ST_START: begin
                if (sample_c) begin
                    cnt_d     = div_q - ClkDivWidth'(1);
                    bit_idx_d = 3'd0;
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (sample_c) begin
                    cnt_d   = div_q - ClkDivWidth'(1);
                    shreg_d = {rx_s, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (sample_c) begin
                    cnt_d   = div_q - ClkDivWidth'(1);
                    state_d = ST_STOP;
                    if (((^shreg_q) ^ rx_s) != par_odd_q) begin
                        parity_err_d = 1'b1;
                        perr_d       = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (sample_c) begin
                    if (rx_s) begin
                        push_c  = !perr_q;
                        state_d = ST_IDLE;
                    end else begin
                        // A parity error already flagged this frame
                        frame_err_d = !perr_q;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and registered status outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            div_q        <= MinDiv;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            perr_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            perr_q       <= perr_d;
            busy_q       <= (state_d != ST_IDLE);
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign busy_o       = busy_q;
    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;

    logic [7:0]      mem_q [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            full_c, pop_c, wr_en_c;
    logic            overflow_q;

    assign full_c  = (count_q == CntW'(FifoDepth));
    assign pop_c   = valid_o && ready_i;
    // A pop in the same cycle frees the slot for a push into a full FIFO
    assign wr_en_c = push_c && (!full_c || pop_c);

    // Byte FIFO; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(FifoDepth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en_c) begin
                mem_q[wr_ptr_q] <= shreg_q;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({wr_en_c, pop_c})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            overflow_q <= push_c && full_c && !pop_c;
        end
    end

    assign data_o     = mem_q[rd_ptr_q];
    assign valid_o    = (count_q != '0);
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_pb_uart_rx_capture.sv
// tb_pb_uart_rx_capture: self-checking bench for pb_uart_rx_capture.
// A serial transmitter drives frames; expected bytes, error counts and
// latencies come from frame-level rules (bit period, parity, FIFO depth).
module tb_pb_uart_rx_capture;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] clk_div_i = 16'd16;
    logic        parity_en_i = 1'b0;
    logic        parity_odd_i = 1'b0;
    logic        rx_i = 1'b1;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        busy_o;
    logic        frame_err_o;
    logic        parity_err_o;
    logic        overflow_o;

    pb_uart_rx_capture #(
        .FifoDepth  (8),
        .ClkDivWidth(16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .clk_div_i   (clk_div_i),
        .parity_en_i (parity_en_i),
        .parity_odd_i(parity_odd_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .frame_err_o (frame_err_o),
        .parity_err_o(parity_err_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         fs = 0;
    int         rise_cyc = -1;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    int         ov_cnt = 0;
    int         valid_hi = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor: error pulse cycles are counted, so a stuck pulse shows up
    always @(negedge clk) begin
        if (valid_o === 1'b1 && ready_i === 1'b1) got_q.push_back(data_o);
        if (frame_err_o === 1'b1) fe_cnt++;
        if (parity_err_o === 1'b1) pe_cnt++;
        if (overflow_o === 1'b1) ov_cnt++;
        if (valid_o === 1'b1) valid_hi++;
        if (valid_o === 1'b1 && valid_prev !== 1'b1) rise_cyc = cyc;
        valid_prev = valid_o;
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Transmits one frame; configuration is scrambled after the start bit
    task automatic send_frame(input logic [7:0] d, input int div_cfg, input bit pen,
                              input bit podd, input bit pflip, input bit stop_val);
        int blen;
        blen = (div_cfg < 4) ? 4 : div_cfg;
        @(posedge clk); #2;
        clk_div_i    = 16'(div_cfg);
        parity_en_i  = pen;
        parity_odd_i = podd;
        rx_i = 1'b0;
        fs   = cyc;
        hold(blen);
        clk_div_i    = 16'($urandom_range(0, 40));
        parity_en_i  = 1'($urandom);
        parity_odd_i = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            hold(blen);
        end
        if (pen) begin
            rx_i = (^d) ^ podd ^ pflip;
            hold(blen);
        end
        rx_i = stop_val;
        hold(blen);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        hold(4);
        @(negedge clk);
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_cmp++; if (data_o !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", data_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_cmp++; if ({frame_err_o, parity_err_o, overflow_o} !== 3'b000) begin
            n_err++; $display("FAIL reset_errs: got %b want 000", {frame_err_o, parity_err_o, overflow_o});
        end
        hold(1);
        rst_i = 1'b0;
        hold(3);
    endtask

    task automatic test_basic();
        int fe0, pe0, ov0, vh0;
        got_q.delete();
        ready_i = 1'b1;
        rise_cyc = -1;
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt; vh0 = valid_hi;
        send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b1);
        hold(10);
        n_cmp++; if (rise_cyc - fs !== 155) begin n_err++; $display("FAIL basic_latency: got %0d want 155", rise_cyc - fs); end
        n_cmp++; if (got_q.size() !== 1) begin n_err++; $display("FAIL basic_count: got %0d want 1", got_q.size()); end
        n_cmp++; if (got_q.size() > 0 && got_q[0] !== 8'hA5) begin n_err++; $display("FAIL basic_data: got %h want a5", got_q[0]); end
        n_cmp++; if (valid_hi - vh0 !== 1) begin n_err++; $display("FAIL basic_valid_width: got %0d want 1", valid_hi - vh0); end
        n_cmp++; if (fe_cnt - fe0 + pe_cnt - pe0 + ov_cnt - ov0 !== 0) begin
            n_err++; $display("FAIL basic_errs: got %0d want 0", fe_cnt - fe0 + pe_cnt - pe0 + ov_cnt - ov0);
        end
    endtask

    task automatic test_parity();
        int pe0, fe0;
        got_q.delete();
        ready_i = 1'b1;
        pe0 = pe_cnt; fe0 = fe_cnt;
        send_frame(8'h03, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        hold(10);
        n_cmp++; if (got_q.size() !== 1) begin n_err++; $display("FAIL parity_good_count: got %0d want 1", got_q.size()); end
        n_cmp++; if (got_q.size() > 0 && got_q[0] !== 8'h03) begin n_err++; $display("FAIL parity_good_data: got %h want 03", got_q[0]); end
        n_cmp++; if (pe_cnt !== pe0) begin n_err++; $display("FAIL parity_good_err: got %0d want %0d", pe_cnt, pe0); end
        send_frame(8'h03, 8, 1'b1, 1'b0, 1'b1, 1'b1);
        hold(10);
        @(negedge clk);
        n_cmp++; if (pe_cnt - pe0 !== 1) begin n_err++; $display("FAIL parity_bad_pulse: got %0d want 1", pe_cnt - pe0); end
        n_cmp++; if (got_q.size() !== 1) begin n_err++; $display("FAIL parity_bad_drop: got %0d want 1", got_q.size()); end
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL parity_bad_empty: got %b want 0", valid_o); end
        n_cmp++; if (fe_cnt !== fe0) begin n_err++; $display("FAIL parity_bad_fe: got %0d want %0d", fe_cnt, fe0); end
    endtask

    task automatic test_glitch();
        int fe0, pe0;
        got_q.delete();
        fe0 = fe_cnt; pe0 = pe_cnt;
        @(posedge clk); #2;
        clk_div_i = 16'd16;
        rx_i = 1'b0;
        fs = cyc;
        hold(3);
        rx_i = 1'b1;
        while (cyc < fs + 10) @(negedge clk);
        n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL glitch_busy_t0p8: got %b want 1", busy_o); end
        @(negedge clk);
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL glitch_idle_t0p9: got %b want 0", busy_o); end
        hold(40);
        n_cmp++; if (got_q.size() + fe_cnt - fe0 + pe_cnt - pe0 !== 0) begin
            n_err++; $display("FAIL glitch_nothing: got %0d want 0", got_q.size() + fe_cnt - fe0 + pe_cnt - pe0);
        end
    endtask

    task automatic test_break();
        int fe0;
        got_q.delete();
        fe0 = fe_cnt;
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(40 * 16);
        @(negedge clk);
        n_cmp++; if (fe_cnt - fe0 !== 1) begin n_err++; $display("FAIL break_fe: got %0d want 1", fe_cnt - fe0); end
        n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL break_busy_held: got %b want 1", busy_o); end
        n_cmp++; if (got_q.size() !== 0) begin n_err++; $display("FAIL break_nobyte: got %0d want 0", got_q.size()); end
        hold(1);
        rx_i = 1'b1;
        hold(5);
        @(negedge clk);
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL break_release: got %b want 0", busy_o); end
        hold(60);
        @(negedge clk);
        n_cmp++; if (busy_o !== 1'b0 || fe_cnt - fe0 !== 1) begin
            n_err++; $display("FAIL break_no_restart: got busy %b fe %0d want 0/1", busy_o, fe_cnt - fe0);
        end
    endtask

    task automatic test_random();
        int exp_fe, exp_pe, fe0, pe0;
        got_q.delete();
        exp_q.delete();
        ready_i = 1'b1;
        exp_fe = 0; exp_pe = 0;
        fe0 = fe_cnt; pe0 = pe_cnt;
        for (int f = 0; f < 20; f++) begin
            logic [7:0] d;
            int  dv;
            bit  pen, podd, pflip, stp, bad;
            d     = 8'($urandom);
            dv    = $urandom_range(0, 24);
            pen   = 1'($urandom);
            podd  = 1'($urandom);
            pflip = ($urandom_range(0, 3) == 0);
            stp   = ($urandom_range(0, 4) != 0);
            bad   = pen && pflip;
            if (bad) exp_pe++;
            else if (!stp) exp_fe++;
            else exp_q.push_back(d);
            send_frame(d, dv, pen, podd, pflip, stp);
            rx_i = 1'b1;
            hold($urandom_range(3, 20));
        end
        hold(20);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [7:0] obs;
            obs = (i < got_q.size()) ? got_q[i] : 8'hxx;
            n_cmp++; if (obs !== exp_q[i]) begin n_err++; $display("FAIL rand_byte%0d: got %h want %h", i, obs, exp_q[i]); end
        end
        n_cmp++; if (fe_cnt - fe0 !== exp_fe) begin n_err++; $display("FAIL rand_fe: got %0d want %0d", fe_cnt - fe0, exp_fe); end
        n_cmp++; if (pe_cnt - pe0 !== exp_pe) begin n_err++; $display("FAIL rand_pe: got %0d want %0d", pe_cnt - pe0, exp_pe); end
    endtask

    task automatic test_overflow();
        int ov0, exp_ov;
        logic [7:0] fifo_m[$];
        got_q.delete();
        ready_i = 1'b0;
        ov0 = ov_cnt; exp_ov = 0;
        for (int b = 0; b < 9; b++) begin
            if (fifo_m.size() < 8) fifo_m.push_back(8'(b));
            else exp_ov++;
            send_frame(8'(b), 8, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        hold(5);
        @(negedge clk);
        n_cmp++; if (ov_cnt - ov0 !== exp_ov) begin n_err++; $display("FAIL ovf_pulse: got %0d want %0d", ov_cnt - ov0, exp_ov); end
        n_cmp++; if (valid_o !== 1'b1 || data_o !== fifo_m[0]) begin
            n_err++; $display("FAIL ovf_head: got %b/%h want 1/%h", valid_o, data_o, fifo_m[0]);
        end
        hold(1);
        ready_i = 1'b1;
        hold(20);
        @(negedge clk);
        n_cmp++; if (got_q.size() !== fifo_m.size()) begin n_err++; $display("FAIL ovf_drain_count: got %0d want %0d", got_q.size(), fifo_m.size()); end
        for (int i = 0; i < fifo_m.size(); i++) begin
            logic [7:0] obs;
            obs = (i < got_q.size()) ? got_q[i] : 8'hxx;
            n_cmp++; if (obs !== fifo_m[i]) begin n_err++; $display("FAIL ovf_drain%0d: got %h want %h", i, obs, fifo_m[i]); end
        end
        n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b want 0", valid_o); end
    endtask

    task automatic test_back_to_back();
        int ov0;
        logic [7:0] fifo_m[$];
        got_q.delete();
        ready_i = 1'b0;
        ov0 = ov_cnt;
        for (int b = 0; b < 8; b++) begin
            fifo_m.push_back(8'(8'h10 + b));
            send_frame(8'(8'h10 + b), 8, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        // Stop sample of the 9th frame lands at start + 2 + 4 + 9*8
        fork
            send_frame(8'h18, 8, 1'b0, 1'b0, 1'b0, 1'b1);
            begin
                @(posedge clk); #3;
                for (int k = 0; k < 500 && cyc != fs + 78; k++) begin
                    @(posedge clk); #2;
                end
                ready_i = 1'b1;
                @(posedge clk); #2;
                ready_i = 1'b0;
            end
        join
        void'(fifo_m.pop_front());
        fifo_m.push_back(8'h18);
        hold(5);
        n_cmp++; if (ov_cnt !== ov0) begin n_err++; $display("FAIL full_pop_ovf: got %0d want %0d", ov_cnt - ov0, 0); end
        n_cmp++; if (got_q.size() !== 1 || got_q[0] !== 8'h10) begin
            n_err++; $display("FAIL full_pop_first: got %0d entries want 1 (10)", got_q.size());
        end
        ready_i = 1'b1;
        hold(20);
        for (int i = 0; i < fifo_m.size(); i++) begin
            logic [7:0] obs;
            obs = (i + 1 < got_q.size()) ? got_q[i + 1] : 8'hxx;
            n_cmp++; if (obs !== fifo_m[i]) begin n_err++; $display("FAIL full_pop_drain%0d: got %h want %h", i, obs, fifo_m[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        got_q.delete();
        ready_i = 1'b0;
        send_frame(8'h77, 16, 1'b0, 1'b0, 1'b0, 1'b1);
        hold(4);
        @(negedge clk);
        n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL rstmid_prefill: got %b want 1", valid_o); end
        hold(1);
        d = 8'hE7;
        clk_div_i = 16'd16;
        parity_en_i = 1'b0;
        rx_i = 1'b0;
        hold(16);
        for (int i = 0; i < 4; i++) begin
            rx_i = d[i];
            hold(16);
        end
        rx_i = d[4];
        hold(8);
        rst_i = 1'b1;
        rx_i = 1'b1;
        hold(3);
        rst_i = 1'b0;
        hold(2);
        @(negedge clk);
        n_cmp++; if (valid_o !== 1'b0 || data_o !== 8'h00) begin
            n_err++; $display("FAIL rstmid_fifo: got %b/%h want 0/00", valid_o, data_o);
        end
        n_cmp++; if ({busy_o, frame_err_o, parity_err_o, overflow_o} !== 4'b0000) begin
            n_err++; $display("FAIL rstmid_status: got %b want 0000", {busy_o, frame_err_o, parity_err_o, overflow_o});
        end
        ready_i = 1'b1;
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1);
        hold(10);
        n_cmp++; if (got_q.size() !== 1 || got_q[0] !== 8'h3C) begin
            n_err++; $display("FAIL rstmid_next: got %0d entries want 1 (3c)", got_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_break();
        test_random();
        test_overflow();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
